// File: rtl/simm_pattern_tester.sv
// simm_pattern_tester
// Pattern-test initiator for the SIMM DRAM controller request interface.
// Each pass writes pat(a,seed) = a[7:0]^a[15:8]^a[23:16]^seed over 0..LAST_ADDR,
// then reads the range back and compares every byte. The seed starts at 0 and
// advances by 8'h5B per pass. Mismatches are counted (saturating), the first
// one is captured, and a per-request watchdog aborts the run on a stalled
// controller.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   start                   one-cycle pulse, begins a run when idle
//   mem_addr/mem_write/mem_ena/mem_wr_data   request to controller
//   mem_rd_data/mem_busy/mem_ack             controller response
//   running/done/timeout    run status (done/timeout held until next start)
//   pass_cnt, err_cnt       completed passes, saturating mismatch count
//   first_err_addr/exp/got  details of the first mismatch
module simm_pattern_tester #(
  parameter int unsigned       ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}},
  parameter int unsigned       NUM_PASSES = 4,
  parameter int unsigned       TIMEOUT    = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic              mem_ena,
  output logic [7:0]        mem_wr_data,
  input  logic [7:0]        mem_rd_data,
  input  logic              mem_busy,
  input  logic              mem_ack,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic [7:0]        pass_cnt,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [7:0]        first_err_exp,
  output logic [7:0]        first_err_got
);

  localparam int unsigned TW        = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  SEED_STEP = 8'h5B;

  typedef enum logic [2:0] {IDLE, W_REQ, W_WAIT, R_REQ, R_WAIT, CHECK, FIN} state_t;

  state_t            state;
  logic [7:0]        seed;
  logic [7:0]        rd_byte;
  logic [TW-1:0]     tmo_cnt;

  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        seed_nxt;
  logic [7:0]        exp_byte;
  logic              tmo_hit;

  // Address bytes above ADDR_W read as zero.
  function automatic logic [7:0] pat(input logic [ADDR_W-1:0] a, input logic [7:0] s);
    logic [23:0] a24;
    a24 = '0;
    a24[ADDR_W-1:0] = a;
    return a24[7:0] ^ a24[15:8] ^ a24[23:16] ^ s;
  endfunction

  always_comb begin
    addr_nxt = mem_addr + 1'b1;
    seed_nxt = seed + SEED_STEP;
    exp_byte = pat(mem_addr, seed);
    tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));
  end

  // Request outputs are loaded on every transition into *_REQ so they are
  // already valid in the first request cycle and stay frozen until ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      seed           <= '0;
      rd_byte        <= '0;
      tmo_cnt        <= '0;
      mem_addr       <= '0;
      mem_write      <= 1'b0;
      mem_ena        <= 1'b0;
      mem_wr_data    <= '0;
      running        <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      pass_cnt       <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            done           <= 1'b0;
            timeout        <= 1'b0;
            pass_cnt       <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
            running        <= 1'b1;
            seed           <= '0;
            mem_addr       <= '0;
            mem_write      <= 1'b1;
            mem_ena        <= 1'b1;
            mem_wr_data    <= pat('0, 8'h00);
            tmo_cnt        <= '0;
            state          <= W_REQ;
          end
        end

        W_REQ, R_REQ: begin
          if (tmo_hit) begin
            timeout <= 1'b1;
            mem_ena <= 1'b0;
            state   <= FIN;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (mem_ack) begin
              mem_ena <= 1'b0;
              state   <= (state == W_REQ) ? W_WAIT : R_WAIT;
            end
          end
        end

        W_WAIT: begin
          if (tmo_hit) begin
            timeout <= 1'b1;
            mem_ena <= 1'b0;
            state   <= FIN;
          end else if (!mem_busy) begin
            tmo_cnt <= '0;
            mem_ena <= 1'b1;
            if (mem_addr == LAST_ADDR) begin
              mem_addr    <= '0;
              mem_write   <= 1'b0;
              mem_wr_data <= pat('0, seed);
              state       <= R_REQ;
            end else begin
              mem_addr    <= addr_nxt;
              mem_write   <= 1'b1;
              mem_wr_data <= pat(addr_nxt, seed);
              state       <= W_REQ;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        R_WAIT: begin
          if (tmo_hit) begin
            timeout <= 1'b1;
            mem_ena <= 1'b0;
            state   <= FIN;
          end else if (!mem_busy) begin
            rd_byte <= mem_rd_data;
            state   <= CHECK;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        CHECK: begin
          if (rd_byte != exp_byte) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (err_cnt == '0) begin
              first_err_addr <= mem_addr;
              first_err_exp  <= exp_byte;
              first_err_got  <= rd_byte;
            end
          end
          if (mem_addr < LAST_ADDR) begin
            mem_addr    <= addr_nxt;
            mem_write   <= 1'b0;
            mem_ena     <= 1'b1;
            mem_wr_data <= pat(addr_nxt, seed);
            tmo_cnt     <= '0;
            state       <= R_REQ;
          end else begin
            pass_cnt <= pass_cnt + 8'd1;
            if ((pass_cnt + 8'd1) == 8'(NUM_PASSES)) begin
              state <= FIN;
            end else begin
              mem_addr    <= '0;
              seed        <= seed_nxt;
              mem_write   <= 1'b1;
              mem_ena     <= 1'b1;
              mem_wr_data <= pat('0, seed_nxt);
              tmo_cnt     <= '0;
              state       <= W_REQ;
            end
          end
        end

        FIN: begin
          running <= 1'b0;
          done    <= 1'b1;
          mem_ena <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
